mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
Sequential controller that sits directly upstream of the NAND-built 4:1 MUX stage.
- Accepts a 4-bit word over a valid/ready handshake and drives it onto the MUX data inputs C0..C3.
- Steps the S0/S1 selects through all four channels, waiting a programmable settle time per channel so the switch-level gate delays resolve.
- Samples the MUX output z, emits it as a serial bit stream, and reassembles the word for a loopback check against the driven value.

Parameters:
SETTLE, 8, clock cycles held after each select change before z is sampled; legal range 1..15, 0 is illegal.
CW, 4, width of the settle counter; must satisfy 2^CW > SETTLE.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  4  word to drive; din[i] goes to channel i
din_valid  input  1  din is valid
din_ready  output  1  block can accept din
c  output  4  to MUX C3..C0 (c[i] drives Ci)
s0  output  1  to MUX S0
s1  output  1  to MUX S1
z  input  1  MUX output
dout_bit  output  1  sampled z, serial stream
bit_valid  output  1  one-cycle pulse qualifying dout_bit
word_out  output  4  reassembled word; word_out[i] = z sampled on channel i
word_valid  output  1  word_out and mismatch are valid
word_ready  input  1  consumer accepts word_out
mismatch  output  1  word_out != c, qualified by word_valid
err_cnt  output  8  saturating count of mismatching words
busy  output  1  high in any state other than IDLE

Behaviour:
- Channel mapping (fixed by the downstream MUX): channel index i = 2*s0 + s1.
  - s0=0,s1=0 selects C0; s0=0,s1=1 selects C1; s0=1,s1=0 selects C2; s0=1,s1=1 selects C3.
  - Scan order is channel 0,1,2,3.
- Reset (rst_n low, asynchronous): state=IDLE, c=0, sel=0 (so s0=s1=0), cnt=0, capture register=0, dout_bit=0, bit_valid=0, word_out=0, mismatch=0, err_cnt=0.
  - Decoded outputs while in reset: din_ready=1, word_valid=0, busy=0.
  - Reset mid-scan aborts the word immediately; no word_valid is produced for it.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - din_ready = (state==IDLE).
  - word_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE: on a clock edge with din_valid & din_ready: c<=din, sel<=0, cnt<=0, go to SETTLE. din is ignored in every other state.
- SETTLE:
  - if cnt==SETTLE-1, go to SAMPLE;
  - else cnt<=cnt+1.
  - Lasts exactly SETTLE cycles.
- SAMPLE: lasts one cycle. At its closing edge: capture[sel]<=z, dout_bit<=z, bit_valid<=1 for the next cycle only.
  - if sel==3: word_out<={z,capture[2:0]}, mismatch<=({z,capture[2:0]}!=c), go to DONE.
  - else: sel<=sel+1, cnt<=0, go to SETTLE.
- DONE: holds word_out, mismatch and c stable until word_ready.
  - On the edge with word_ready=1: go to IDLE; err_cnt<=err_cnt+1 if mismatch and err_cnt<255 (saturates at 255, no wrap).
  - Because din_ready=0 in DONE, din_valid in the same cycle is not accepted; the earliest accept is the following cycle.
- Latency: word_valid first asserts 4*(SETTLE+1) cycles after the accepting edge (36 cycles at SETTLE=8).
  - Minimum accept-to-accept spacing is 4*(SETTLE+1)+2 cycles.
- c and sel change only on the accept edge and on SAMPLE exits. s0/s1 are direct register bits, glitch-free toward the MUX.
- c retains the last word after DONE until the next accept.

Test Plan:
1. Reset mid-operation: accept din=4'hA, pull rst_n low during the second SETTLE -> immediately c=0, s0=s1=0, busy=0, din_ready=1, err_cnt=0; no word_valid ever pulses for that word.
2. Loopback with the real NAND MUX stage, 10 ns clock, SETTLE=8, din=4'b1010 -> (s0,s1) sequence (0,0),(0,1),(1,0),(1,1); bit_valid pulses carry dout_bit 0,1,0,1; word_valid at cycle 36 after accept; word_out=4'b1010, mismatch=0.
3. z forced to 0, din=4'hF -> word_out=4'h0, mismatch=1; err_cnt goes 0->1 on the word_ready edge.
4. Backpressure: word_ready held low 10 cycles in DONE with din_valid=1, din=4'h3 -> word_valid, word_out and c stay stable, din_ready=0, no accept; raise word_ready -> IDLE next cycle; din=4'h3 accepted one cycle later.
5. Saturation: 257 consecutive mismatching words (z stuck at 0, din=4'hF) -> err_cnt reads 255 after the 255th word and stays 255.
6. SETTLE=1 with an ideal zero-delay MUX model, din=4'b0110 -> 8 cycles from accept to word_valid; word_out=4'b0110, mismatch=0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives a 4-bit word into the NAND 4:1 MUX and scans channels 0..3.
// Each channel settles for SETTLE cycles before z is sampled; the samples are reassembled and checked.
module mux_scan_ctrl #(
    parameter int SETTLE = 8,
    parameter int CW     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [3:0] c,
    output logic       s0,
    output logic       s1,
    input  logic       z,
    output logic       dout_bit,
    output logic       bit_valid,
    output logic [3:0] word_out,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       mismatch,
    output logic [7:0] err_cnt,
    output logic       busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    state_t        state_q;
    logic [3:0]    c_q, cap_q, word_q;
    logic [1:0]    sel_q;
    logic [CW-1:0] cnt_q;
    logic          dout_q, bv_q, mis_q;
    logic [7:0]    err_q;
    logic [3:0]    word_d;

    assign word_d = {z, cap_q[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            dout_q  <= 1'b0;
            bv_q    <= 1'b0;
            word_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            bv_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (din_valid) begin
                    c_q     <= din;
                    sel_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: if (cnt_q == LAST) state_q <= ST_SAMPLE;
                           else cnt_q <= cnt_q + 1'b1;
                ST_SAMPLE: begin
                    cap_q[sel_q] <= z;
                    dout_q       <= z;
                    bv_q         <= 1'b1;
                    if (sel_q == 2'd3) begin
                        word_q  <= word_d;
                        mis_q   <= (word_d != c_q);
                        state_q <= ST_DONE;
                    end else begin
                        sel_q   <= sel_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_DONE: if (word_ready) begin
                    state_q <= ST_IDLE;
                    if (mis_q && err_q != 8'hFF) err_q <= err_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Selects come straight from register bits so the MUX never sees decode glitches.
    assign s0         = sel_q[1];
    assign s1         = sel_q[0];
    assign c          = c_q;
    assign dout_bit   = dout_q;
    assign bit_valid  = bv_q;
    assign word_out   = word_q;
    assign mismatch   = mis_q;
    assign err_cnt    = err_q;
    assign din_ready  = (state_q == ST_IDLE);
    assign word_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
endmodule
